mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Control unit for the multicycle MIPS datapath: decodes Op/Funct and steps a Moore FSM that drives every mux select and write enable of the shared-memory datapath.
- Sits inside the mips core beside the datapath.
- A single combined instruction/data memory is addressed through IorD.

Parameters:
- MEM_WAIT, 0, extra wait cycles spent in each memory-access state (FETCH, MEMRD, MEMWR) before the access completes; legal range 0..15.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Op  in  6  Instr[31:26] from the instruction register.
- Funct  in  6  Instr[5:0] from the instruction register.
- Zero  in  1  ALU zero flag.
- PCEn  out  1  PC register enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register enable.
- RegDst  out  1  register write destination: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = Data.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUControl  out  3  ALU operation code.
- State  out  4  current FSM state, for debug.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 are illegal and go to FETCH on the next edge.
- Reset:
  - State=FETCH and the wait counter is cleared.
  - While Reset is high, PCEn, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0.
  - All select outputs show FETCH values.
- Transitions:
  - FETCH to DECODE.
  - DECODE by Op:
    - lw 100011 / sw 101011 go to MEMADR.
    - R-type 000000 goes to EXECUTE.
    - beq 000100 goes to BRANCH.
    - addi 001000 goes to ADDIEXEC.
    - j 000010 goes to JUMP.
    - Any other Op goes to FETCH with InstrDone=1 (executes as a nop).
  - MEMADR goes to MEMRD for lw, MEMWR for sw.
  - MEMRD to MEMWB; EXECUTE to ALUWB; ADDIEXEC to ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP go to FETCH.
- Outputs are Moore per state; every unlisted signal is 0. ALUOp: 00 = add, 01 = sub, 10 = by Funct.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & Zero). This is the only Zero-dependent output and is combinational.
- ALUControl:
  - ALUOp 00 gives 010; ALUOp 01 gives 110.
  - ALUOp 10 decodes Funct: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111, any other Funct gives 010.
- InstrDone is high in MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP, and in DECODE for an unknown Op.
- MEM_WAIT handling:
  - FETCH, MEMRD and MEMWR each hold for MEM_WAIT+1 cycles.
  - A 4-bit counter starts at 0 on state entry.
  - IRWrite, PCEn (in FETCH) and MemWrite assert only on the final cycle of the hold. Select outputs are stable for the whole hold.
  - Within MEMWR, InstrDone asserts only on the final cycle.
  - With MEM_WAIT=0 the hold is a single cycle, so behaviour is identical to an unstretched FSM.
- Reset asserted mid-instruction returns the FSM to FETCH immediately and asynchronously. No partial write enable may be produced after Reset rises.
- Cycle counts at MEM_WAIT=0: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown Op 2.

Optional Feature:
- Macro MC_CTRL_BNE_EN.
- When defined:
  - Op 000101 (bne) goes from DECODE to BRANCH.
  - In BRANCH, PCEn = Branch & ~Zero for bne, selected by a registered flag latched in DECODE.
  - beq is unchanged.
- When undefined, Op 000101 is an unknown Op and executes as a nop.

Test Plan:
- Reset held 3 cycles, then released, with Op=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; IorD=1 in states 3 and 4... correction: IorD=1 in state 3 only.
- R-type Op=000000 with Funct 100010, then 101010 -> ALUControl=110, then 111 in EXECUTE; RegDst=1 and RegWrite=1 in ALUWB; 4 cycles each.
- beq with Zero=1, then Zero=0 -> PCEn=1 in BRANCH with PCSrc=01 only when Zero=1; 3 cycles each; InstrDone pulses once per instruction.
- MEM_WAIT=2, sw -> FETCH lasts 3 cycles with IRWrite=1 only on the 3rd; MEMWR lasts 3 cycles with MemWrite=1 only on the 3rd; 8 cycles total.
- Reset asserted mid-MEMWR -> State=0 and MemWrite=0 in the same cycle; after release, a clean FETCH follows.
- Op=000101 with Zero=0 -> with MC_CTRL_BNE_EN: BRANCH taken and PCEn=1; without it: sequence FETCH, DECODE, FETCH with no PCEn outside FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM plus ALU decoder.
// Optional bne support is enabled with `define MC_CTRL_BNE_EN.
module mc_controller #(
  parameter int MEM_WAIT = 0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCEn,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] State,
  output logic       InstrDone
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpRtyp = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OpBne  = 6'b000101;
`endif

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last;
  logic       op_known;

  logic       pcwrite, branch, take;
  logic [1:0] aluop;
  logic       irw, mw, rw, done;

  assign last = (cnt_q == WaitLast);

  always_comb begin
    op_known = (Op == OpLw) || (Op == OpSw) ||
               (Op == OpRtyp) || (Op == OpBeq) ||
               (Op == OpAddi) || (Op == OpJ);
`ifdef MC_CTRL_BNE_EN
    op_known = op_known || (Op == OpBne);
`endif
  end

  // Memory states hold until the wait counter reaches MEM_WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_FETCH: begin
        if (last) state_d = S_DECODE;
        else      cnt_d   = cnt_q + 4'd1;
      end
      S_DECODE: begin
        unique case (1'b1)
          (Op == OpLw),
          (Op == OpSw):   state_d = S_MEMADR;
          (Op == OpRtyp): state_d = S_EXECUTE;
          (Op == OpBeq):  state_d = S_BRANCH;
          (Op == OpAddi): state_d = S_ADDIEXEC;
          (Op == OpJ):    state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
          (Op == OpBne):  state_d = S_BRANCH;
`endif
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = (Op == OpLw) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (last) state_d = S_MEMWB;
        else      cnt_d   = cnt_q + 4'd1;
      end
      S_MEMWR: begin
        if (last) state_d = S_FETCH;
        else      cnt_d   = cnt_q + 4'd1;
      end
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

`ifdef MC_CTRL_BNE_EN
  logic bne_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) bne_q <= (Op == OpBne);
    end
  end

  assign take = bne_q ? ~Zero : Zero;
`else
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign take = Zero;
`endif

  always_comb begin
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    aluop    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    irw      = 1'b0;
    mw       = 1'b0;
    rw       = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        irw     = last;
        pcwrite = last;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        done    = ~op_known;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        rw       = 1'b1;
        done     = 1'b1;
      end
      S_MEMWR: begin
        IorD = 1'b1;
        mw   = last;
        done = last;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        rw     = 1'b1;
        done   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        aluop   = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_ADDIWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b010;
    case (aluop)
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  // Enables are masked so nothing writes while Reset is high.
  assign PCEn      = ~Reset & (pcwrite | (branch & take));
  assign IRWrite   = ~Reset & irw;
  assign MemWrite  = ~Reset & mw;
  assign RegWrite  = ~Reset & rw;
  assign InstrDone = ~Reset & done;
  assign State     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller at MEM_WAIT=0 and MEM_WAIT=2.
module tb_mc_controller;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Zero = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;

  logic       a_pcen, a_iord, a_mw, a_irw, a_rdst, a_m2r, a_rw;
  logic       a_srca, a_done;
  logic [1:0] a_srcb, a_pcsrc;
  logic [2:0] a_alu;
  logic [3:0] a_st;

  logic       b_pcen, b_iord, b_mw, b_irw, b_rdst, b_m2r, b_rw;
  logic       b_srca, b_done;
  logic [1:0] b_srcb, b_pcsrc;
  logic [2:0] b_alu;
  logic [3:0] b_st;

  int checks = 0;
  int failures = 0;

  mc_controller #(.MEM_WAIT(0)) u0 (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(a_pcen), .IorD(a_iord), .MemWrite(a_mw), .IRWrite(a_irw),
    .RegDst(a_rdst), .MemtoReg(a_m2r), .RegWrite(a_rw),
    .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .PCSrc(a_pcsrc),
    .ALUControl(a_alu), .State(a_st), .InstrDone(a_done)
  );

  mc_controller #(.MEM_WAIT(2)) u2 (
    .CLK(CLK), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCEn(b_pcen), .IorD(b_iord), .MemWrite(b_mw), .IRWrite(b_irw),
    .RegDst(b_rdst), .MemtoReg(b_m2r), .RegWrite(b_rw),
    .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .PCSrc(b_pcsrc),
    .ALUControl(b_alu), .State(b_st), .InstrDone(b_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ea(input string tag, input logic [3:0] st,
                    input logic pcen, input logic irw, input logic mw,
                    input logic rw, input logic done);
    chk({tag, ".State"}, a_st, st);
    chk({tag, ".PCEn"}, {3'b0, a_pcen}, {3'b0, pcen});
    chk({tag, ".IRWrite"}, {3'b0, a_irw}, {3'b0, irw});
    chk({tag, ".MemWrite"}, {3'b0, a_mw}, {3'b0, mw});
    chk({tag, ".RegWrite"}, {3'b0, a_rw}, {3'b0, rw});
    chk({tag, ".InstrDone"}, {3'b0, a_done}, {3'b0, done});
  endtask

  task automatic eb(input string tag, input logic [3:0] st,
                    input logic pcen, input logic irw, input logic mw,
                    input logic rw, input logic done);
    chk({tag, ".State"}, b_st, st);
    chk({tag, ".PCEn"}, {3'b0, b_pcen}, {3'b0, pcen});
    chk({tag, ".IRWrite"}, {3'b0, b_irw}, {3'b0, irw});
    chk({tag, ".MemWrite"}, {3'b0, b_mw}, {3'b0, mw});
    chk({tag, ".RegWrite"}, {3'b0, b_rw}, {3'b0, rw});
    chk({tag, ".InstrDone"}, {3'b0, b_done}, {3'b0, done});
  endtask

  initial begin
    Op = 6'b100011;
    repeat (3) @(posedge CLK);
    #1;
    ea("rst", 4'd0, 0, 0, 0, 0, 0);
    chk("rst.IorD", {3'b0, a_iord}, 4'd0);
    chk("rst.ALUSrcB", {2'b0, a_srcb}, 4'd1);
    Reset = 1'b0;
    #1;
    // lw
    ea("lw_f", 4'd0, 1, 1, 0, 0, 0);
    chk("lw_f.ALUControl", {1'b0, a_alu}, 4'd2);
    step(); ea("lw_d", 4'd1, 0, 0, 0, 0, 0);
    chk("lw_d.ALUSrcB", {2'b0, a_srcb}, 4'd3);
    step(); ea("lw_a", 4'd2, 0, 0, 0, 0, 0);
    chk("lw_a.ALUSrcA", {3'b0, a_srca}, 4'd1);
    chk("lw_a.ALUSrcB", {2'b0, a_srcb}, 4'd2);
    step(); ea("lw_r", 4'd3, 0, 0, 0, 0, 0);
    chk("lw_r.IorD", {3'b0, a_iord}, 4'd1);
    step(); ea("lw_w", 4'd4, 0, 0, 0, 1, 1);
    chk("lw_w.MemtoReg", {3'b0, a_m2r}, 4'd1);
    chk("lw_w.IorD", {3'b0, a_iord}, 4'd0);
    step(); ea("lw_e", 4'd0, 1, 1, 0, 0, 0);
    // R-type sub
    Op = 6'b000000; Funct = 6'b100010;
    step(); ea("sub_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("sub_x", 4'd6, 0, 0, 0, 0, 0);
    chk("sub_x.ALUControl", {1'b0, a_alu}, 4'd6);
    chk("sub_x.ALUSrcB", {2'b0, a_srcb}, 4'd0);
    step(); ea("sub_w", 4'd7, 0, 0, 0, 1, 1);
    chk("sub_w.RegDst", {3'b0, a_rdst}, 4'd1);
    step(); ea("sub_e", 4'd0, 1, 1, 0, 0, 0);
    // R-type slt
    Funct = 6'b101010;
    step(); ea("slt_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("slt_x", 4'd6, 0, 0, 0, 0, 0);
    chk("slt_x.ALUControl", {1'b0, a_alu}, 4'd7);
    step(); ea("slt_w", 4'd7, 0, 0, 0, 1, 1);
    step(); ea("slt_e", 4'd0, 1, 1, 0, 0, 0);
    // beq taken / not taken
    Op = 6'b000100; Zero = 1'b1;
    step(); ea("beq1_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("beq1_b", 4'd8, 1, 0, 0, 0, 1);
    chk("beq1_b.PCSrc", {2'b0, a_pcsrc}, 4'd1);
    chk("beq1_b.ALUControl", {1'b0, a_alu}, 4'd6);
    step(); ea("beq1_e", 4'd0, 1, 1, 0, 0, 0);
    Zero = 1'b0;
    step(); ea("beq0_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("beq0_b", 4'd8, 0, 0, 0, 0, 1);
    step(); ea("beq0_e", 4'd0, 1, 1, 0, 0, 0);
    // addi
    Op = 6'b001000;
    step(); ea("addi_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("addi_x", 4'd9, 0, 0, 0, 0, 0);
    chk("addi_x.ALUSrcB", {2'b0, a_srcb}, 4'd2);
    step(); ea("addi_w", 4'd10, 0, 0, 0, 1, 1);
    chk("addi_w.RegDst", {3'b0, a_rdst}, 4'd0);
    step(); ea("addi_e", 4'd0, 1, 1, 0, 0, 0);
    // j
    Op = 6'b000010;
    step(); ea("j_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("j_j", 4'd11, 1, 0, 0, 0, 1);
    chk("j_j.PCSrc", {2'b0, a_pcsrc}, 4'd2);
    step(); ea("j_e", 4'd0, 1, 1, 0, 0, 0);
    // sw
    Op = 6'b101011;
    step(); ea("sw_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("sw_a", 4'd2, 0, 0, 0, 0, 0);
    step(); ea("sw_m", 4'd5, 0, 0, 1, 0, 1);
    chk("sw_m.IorD", {3'b0, a_iord}, 4'd1);
    step(); ea("sw_e", 4'd0, 1, 1, 0, 0, 0);
    // unknown op
    Op = 6'b001111;
    step(); ea("nop_d", 4'd1, 0, 0, 0, 0, 1);
    step(); ea("nop_e", 4'd0, 1, 1, 0, 0, 0);
    // bne with Zero=0
    Op = 6'b000101; Zero = 1'b0;
`ifdef MC_CTRL_BNE_EN
    step(); ea("bne_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("bne_b", 4'd8, 1, 0, 0, 0, 1);
    step(); ea("bne_e", 4'd0, 1, 1, 0, 0, 0);
`else
    step(); ea("bne_d", 4'd1, 0, 0, 0, 0, 1);
    step(); ea("bne_e", 4'd0, 1, 1, 0, 0, 0);
`endif
    // beq after bne keeps its own sense
    Op = 6'b000100; Zero = 1'b1;
    step(); ea("beq2_d", 4'd1, 0, 0, 0, 0, 0);
    step(); ea("beq2_b", 4'd8, 1, 0, 0, 0, 1);
    step(); ea("beq2_e", 4'd0, 1, 1, 0, 0, 0);

    // MEM_WAIT=2 sw on u2
    Reset = 1'b1; Zero = 1'b0;
    step();
    Op = 6'b101011;
    Reset = 1'b0;
    #1;
    eb("w_f0", 4'd0, 0, 0, 0, 0, 0);
    chk("w_f0.ALUSrcB", {2'b0, b_srcb}, 4'd1);
    step(); eb("w_f1", 4'd0, 0, 0, 0, 0, 0);
    step(); eb("w_f2", 4'd0, 1, 1, 0, 0, 0);
    step(); eb("w_d", 4'd1, 0, 0, 0, 0, 0);
    step(); eb("w_a", 4'd2, 0, 0, 0, 0, 0);
    step(); eb("w_m0", 4'd5, 0, 0, 0, 0, 0);
    chk("w_m0.IorD", {3'b0, b_iord}, 4'd1);
    step(); eb("w_m1", 4'd5, 0, 0, 0, 0, 0);
    chk("w_m1.IorD", {3'b0, b_iord}, 4'd1);
    step(); eb("w_m2", 4'd5, 0, 0, 1, 0, 1);
    // reset lands in the middle of the write cycle
    Reset = 1'b1;
    #1;
    eb("w_rst", 4'd0, 0, 0, 0, 0, 0);
    step();
    Reset = 1'b0;
    #1;
    eb("w_r0", 4'd0, 0, 0, 0, 0, 0);
    step(); eb("w_r1", 4'd0, 0, 0, 0, 0, 0);
    step(); eb("w_r2", 4'd0, 1, 1, 0, 0, 0);
    step(); eb("w_rd", 4'd1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
